// File: rtl/alu_exec_sequencer.sv
// Operand/result sequencer around a combinational ALU: captures A/B from the bus,
// waits a per-op settle time, latches the 64-bit result into Z and returns it on the bus.
module alu_exec_sequencer #(
   parameter int unsigned ALU_WAIT    = 1,
   parameter int unsigned MULDIV_WAIT = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [4:0]  op_code,
   input  logic [31:0] bus_in,
   input  logic        bus_in_valid,
   output logic        bus_in_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_op,
   input  logic [63:0] alu_c,
   output logic [31:0] bus_out,
   output logic        bus_out_valid,
   input  logic        bus_out_ready,
   output logic [31:0] zhi,
   output logic [31:0] zlo,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned MAX_WAIT = (ALU_WAIT > MULDIV_WAIT) ? ALU_WAIT : MULDIV_WAIT;
   localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [4:0]  OP_MUL   = 5'b01111;
   localparam logic [4:0]  OP_DIV   = 5'b10000;

   typedef enum logic [2:0] {
      IDLE, GET_A, GET_B, EXEC, OUT_LO, OUT_HI, DONE, ERR
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        alu_a_q, alu_a_d;
   logic [31:0]        alu_b_q, alu_b_d;
   logic [4:0]         alu_op_q, alu_op_d;
   logic [31:0]        zhi_q, zhi_d;
   logic [31:0]        zlo_q, zlo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_binary;
   logic               op_unary;
   logic               op_muldiv;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         zhi_q    <= '0;
         zlo_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         zhi_q    <= zhi_d;
         zlo_q    <= zlo_d;
         cnt_q    <= cnt_d;
      end
   end

   // Opcode classes: incoming opcode for dispatch, latched opcode for wait/word count
   always_comb begin
      op_binary = op_code inside {[5'd3:5'd11], OP_MUL, OP_DIV};
      op_unary  = op_code inside {5'd0, 5'd17, 5'd18};
      op_muldiv = (alu_op_q == OP_MUL) || (alu_op_q == OP_DIV);
   end

   always_comb begin
      state_d  = state_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      zhi_d    = zhi_q;
      zlo_d    = zlo_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               alu_op_d = op_code;
               if (op_binary) begin
                  state_d = GET_A;
               end else if (op_unary) begin
                  alu_a_d = '0;
                  state_d = GET_B;
               end else begin
                  state_d = ERR;
               end
            end
         end
         GET_A: begin
            if (bus_in_valid) begin
               alu_a_d = bus_in;
               state_d = GET_B;
            end
         end
         GET_B: begin
            if (bus_in_valid) begin
               alu_b_d = bus_in;
               cnt_d   = op_muldiv ? CNT_W'(MULDIV_WAIT - 1) : CNT_W'(ALU_WAIT - 1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            // Counter holds remaining EXEC cycles minus one; Z latches on the last one
            if (cnt_q == '0) begin
               {zhi_d, zlo_d} = alu_c;
               state_d        = OUT_LO;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         OUT_LO: begin
            if (bus_out_ready) state_d = op_muldiv ? OUT_HI : DONE;
         end
         OUT_HI: begin
            if (bus_out_ready) state_d = DONE;
         end
         DONE, ERR: begin
            alu_op_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only, so no input reaches an output combinationally
   always_comb begin
      alu_a         = alu_a_q;
      alu_b         = alu_b_q;
      alu_op        = alu_op_q;
      zhi           = zhi_q;
      zlo           = zlo_q;
      busy          = (state_q != IDLE);
      bus_in_ready  = (state_q == GET_A) || (state_q == GET_B);
      bus_out_valid = (state_q == OUT_LO) || (state_q == OUT_HI);
      done          = (state_q == DONE);
      err           = (state_q == ERR);
      bus_out       = '0;
      if (state_q == OUT_LO) bus_out = zlo_q;
      if (state_q == OUT_HI) bus_out = zhi_q;
   end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer: a vector table of single operations plus
// hand-written back-pressure, illegal-opcode, ignored-start and mid-op reset sequences.
module tb_alu_exec_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic [4:0]  op_code;
   logic [31:0] bus_in;
   logic        bus_in_valid;
   logic        bus_in_ready;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_op;
   logic [63:0] alu_c;
   logic [31:0] bus_out;
   logic        bus_out_valid;
   logic        bus_out_ready;
   logic [31:0] zhi, zlo;
   logic        busy, done, err;

   int total = 0;
   int bad   = 0;

   alu_exec_sequencer #(.ALU_WAIT(1), .MULDIV_WAIT(4)) dut (
      .clk(clk), .clr(clr), .start(start), .op_code(op_code),
      .bus_in(bus_in), .bus_in_valid(bus_in_valid), .bus_in_ready(bus_in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
      .bus_out(bus_out), .bus_out_valid(bus_out_valid), .bus_out_ready(bus_out_ready),
      .zhi(zhi), .zlo(zlo), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Reference ALU; div returns {remainder, quotient}
   function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] op);
      logic [63:0] dbl;
      logic [4:0]  s;
      s   = b[4:0];
      dbl = {a, a};
      case (op)
         5'd0:  return {32'd0, b};
         5'd3:  return {32'd0, a + b};
         5'd4:  return {32'd0, a - b};
         5'd5:  return {32'd0, a >> s};
         5'd6:  return {32'd0, a << s};
         5'd7:  return {32'd0, 32'($signed(a) >>> s)};
         5'd8:  begin dbl = dbl >> s; return {32'd0, dbl[31:0]}; end
         5'd9:  begin dbl = dbl << s; return {32'd0, dbl[63:32]}; end
         5'd10: return {32'd0, a & b};
         5'd11: return {32'd0, a | b};
         5'd15: return 64'(a) * 64'(b);
         5'd16: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
         5'd17: return {32'd0, 32'd0 - b};
         5'd18: return {32'd0, ~b};
         default: return 64'd0;
      endcase
   endfunction

   always_comb alu_c = alu_model(alu_a, alu_b, alu_op);

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        unary;
      logic        two_words;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
      int          wait_cycles;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int n;
      tick();
      start = 1'b1; op_code = v.op; bus_out_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("alu_op_latched", 64'(alu_op), 64'(v.op));
      if (!v.unary) begin
         chk("ready_get_a", 64'(bus_in_ready), 64'd1);
         bus_in = v.a; bus_in_valid = 1'b1;
         tick();
      end
      chk("ready_get_b", 64'(bus_in_ready), 64'd1);
      bus_in = v.b; bus_in_valid = 1'b1;
      tick();
      bus_in_valid = 1'b0; bus_in = '0;
      chk("no_extra_ready", 64'(bus_in_ready), 64'd0);
      n = 0;
      while (!bus_out_valid && n < 40) begin
         n++;
         tick();
      end
      chk("exec_len", 64'(n), 64'(v.wait_cycles));
      chk("alu_a", 64'(alu_a), v.unary ? 64'd0 : 64'(v.a));
      chk("alu_b", 64'(alu_b), 64'(v.b));
      chk("bus_out_lo", 64'(bus_out), 64'(v.exp_lo));
      chk("z_pair", {zhi, zlo}, {v.exp_hi, v.exp_lo});
      if (v.two_words) begin
         tick();
         chk("valid_hi", 64'(bus_out_valid), 64'd1);
         chk("bus_out_hi", 64'(bus_out), 64'(v.exp_hi));
      end
      tick();
      chk("done_pulse", 64'(done), 64'd1);
      chk("out_idle_value", {31'd0, bus_out_valid, bus_out}, 64'd0);
      tick();
      chk("back_to_idle", {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{5'd3,  32'd5,          32'd7,          1'b0, 1'b0, 32'h0000000C, 32'd0, 1};
      vecs[1]  = '{5'd15, 32'h00010000,   32'h00010000,   1'b0, 1'b1, 32'h00000000, 32'd1, 4};
      vecs[2]  = '{5'd17, 32'd0,          32'd5,          1'b1, 1'b0, 32'hFFFFFFFB, 32'd0, 1};
      vecs[3]  = '{5'd4,  32'd9,          32'd4,          1'b0, 1'b0, 32'h00000005, 32'd0, 1};
      vecs[4]  = '{5'd10, 32'hF0F000FF,   32'h0FF00F0F,   1'b0, 1'b0, 32'h00F0000F, 32'd0, 1};
      vecs[5]  = '{5'd11, 32'h12000034,   32'h00567800,   1'b0, 1'b0, 32'h12567834, 32'd0, 1};
      vecs[6]  = '{5'd6,  32'h00000003,   32'd4,          1'b0, 1'b0, 32'h00000030, 32'd0, 1};
      vecs[7]  = '{5'd18, 32'd0,          32'h0F0F0000,   1'b1, 1'b0, 32'hF0F0FFFF, 32'd0, 1};
      vecs[8]  = '{5'd0,  32'd0,          32'hDEADBEEF,   1'b1, 1'b0, 32'hDEADBEEF, 32'd0, 1};
      vecs[9]  = '{5'd16, 32'd100,        32'd7,          1'b0, 1'b1, 32'd14,       32'd2, 4};
      vecs[10] = '{5'd15, 32'hFFFFFFFF,   32'd2,          1'b0, 1'b1, 32'hFFFFFFFE, 32'd1, 4};

      clr = 1'b1; start = 1'b0; op_code = '0; bus_in = '0;
      bus_in_valid = 1'b0; bus_out_ready = 1'b1;
      tick();
      tick();
      chk("reset_regs", {alu_a, alu_b}, 64'd0);
      chk("reset_z", {zhi, zlo}, 64'd0);
      chk("reset_ctrl", {51'd0, alu_op, bus_out_valid, bus_in_ready, busy, done, err, 1'b0, bus_out == 32'd0},
          64'd1);
      clr = 1'b0;

      foreach (vecs[i]) run_op(vecs[i]);

      // Back-pressure on a single-word result: sub 9-4
      tick();
      start = 1'b1; op_code = 5'd4; bus_out_ready = 1'b0;
      tick();
      start = 1'b0; bus_in = 32'd9; bus_in_valid = 1'b1;
      tick();
      bus_in = 32'd4;
      tick();
      bus_in_valid = 1'b0;
      tick();
      chk("bp_valid", 64'(bus_out_valid), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_word", 64'(bus_out), 64'd5);
         chk("bp_no_done", 64'(done), 64'd0);
         if (i == 3) bus_out_ready = 1'b1;
         tick();
      end
      chk("bp_done", 64'(done), 64'd1);
      tick();
      chk("bp_idle", 64'(busy), 64'd0);

      // Illegal opcode leaves all data registers untouched
      tick();
      start = 1'b1; op_code = 5'b01100;
      tick();
      start = 1'b0;
      chk("ill_err", {61'd0, err, busy, bus_in_ready}, 64'b110);
      chk("ill_op_latched", 64'(alu_op), 64'd12);
      tick();
      chk("ill_idle", {62'd0, err, busy}, 64'd0);
      chk("ill_op_cleared", 64'(alu_op), 64'd0);
      chk("ill_ab_kept", {alu_a, alu_b}, {32'd9, 32'd4});
      chk("ill_z_kept", {zhi, zlo}, {32'd0, 32'd5});

      // start held during EXEC of a mul must be ignored
      tick();
      start = 1'b1; op_code = 5'd15;
      tick();
      start = 1'b0; bus_in = 32'd3; bus_in_valid = 1'b1;
      tick();
      bus_in = 32'd5;
      tick();
      bus_in_valid = 1'b0; start = 1'b1; op_code = 5'd3;
      for (int i = 0; i < 4; i++) begin
         chk("mid_exec_op", 64'(alu_op), 64'd15);
         chk("mid_exec_no_valid", 64'(bus_out_valid), 64'd0);
         tick();
      end
      start = 1'b0;
      chk("mid_exec_lo", {31'd0, bus_out_valid, bus_out}, {31'd0, 1'b1, 32'd15});
      tick();
      chk("mid_exec_hi", {31'd0, bus_out_valid, bus_out}, {31'd0, 1'b1, 32'd0});
      tick();
      chk("mid_exec_done", 64'(done), 64'd1);
      tick();
      chk("mid_exec_idle", 64'(busy), 64'd0);

      // clr during the second EXEC cycle of a div
      tick();
      start = 1'b1; op_code = 5'd16;
      tick();
      start = 1'b0; bus_in = 32'd100; bus_in_valid = 1'b1;
      tick();
      bus_in = 32'd7;
      tick();
      bus_in_valid = 1'b0;
      tick();
      chk("rst_pre_busy", 64'(busy), 64'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("rst_mid_regs", {alu_a, alu_b}, 64'd0);
      chk("rst_mid_z", {zhi, zlo}, 64'd0);
      chk("rst_mid_ctrl", {27'd0, alu_op, bus_out}, 64'd0);
      chk("rst_mid_flags", {59'd0, bus_out_valid, bus_in_ready, busy, done, err}, 64'd0);
      run_op('{5'd3, 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 32'd0, 1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_sequencer.md
# alu_exec_sequencer

Multi-cycle sequencer that sits directly upstream and downstream of the datapath ALU. It captures operands from the shared 32-bit bus into its A (Y) and B registers and drives them, together with a stable 5-bit opcode, into the combinational ALU. After a per-operation settle delay it latches the ALU's 64-bit result into a Z register pair. It then returns the result to the bus: one word for most operations, two words (low, then high) for mul/div.

## Interface
- `ALU_WAIT`, default 1: EXEC cycles for all operations except mul/div (≥1).
- `MULDIV_WAIT`, default 4: EXEC cycles for mul (01111) and div (10000) (≥1).

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on the rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `start` input 1: request a new operation; sampled only in IDLE.
- `op_code` input 5: operation code, sampled with `start`.
- `bus_in` input 32: operand word from the bus.
- `bus_in_valid` input 1: `bus_in` holds a valid operand.
- `bus_in_ready` output 1: block is accepting an operand (GET_A or GET_B).
- `alu_a` output 32: Y register, drives ALU operand A.
- `alu_b` output 32: B register, drives ALU operand B.
- `alu_op` output 5: opcode presented to the ALU.
- `alu_c` input 64: ALU result.
- `bus_out` output 32: result word.
- `bus_out_valid` output 1: `bus_out` holds a valid result word.
- `bus_out_ready` input 1: consumer accepts `bus_out`.
- `zhi`, `zlo` output 32 each: Z register halves.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the operation completes.
- `err` output 1: one-cycle pulse when an opcode is rejected.

## Operation
- **States:** IDLE, GET_A, GET_B, EXEC, OUT_LO, OUT_HI, DONE, ERR.
- **Legal opcodes:**
  - Binary, two operands: 00011 add, 00100 sub, 00101–01001 shifts/rotates, 01010 and, 01011 or, 01111 mul, 10000 div.
  - Unary, one operand: 00000 ld (pass B), 10001 neg, 10010 not.
  - All other opcodes are illegal.
- **IDLE:**
  - `start=1` with an illegal opcode → ERR.
  - `start=1` with a unary opcode → GET_B; `alu_a` is cleared to 0.
  - `start=1` with a binary opcode → GET_A.
  - `op_code` is latched into `alu_op` in all three cases.
  - `alu_op` is 0 while IDLE.
- **Operand capture:**
  - GET_A: on `bus_in_valid`, `alu_a ← bus_in`, → GET_B.
  - GET_B: on `bus_in_valid`, `alu_b ← bus_in`, → EXEC.
  - Without `bus_in_valid` the state holds indefinitely.
- **EXEC:**
  - The counter loads W = `MULDIV_WAIT` for mul/div, otherwise `ALU_WAIT`.
  - EXEC lasts exactly W cycles.
  - At the edge ending the last EXEC cycle: `{zhi,zlo} ← alu_c`, → OUT_LO.
- **OUT_LO:**
  - `bus_out=zlo`, `bus_out_valid=1`.
  - On `bus_out_ready`: mul/div → OUT_HI, others → DONE.
- **OUT_HI:**
  - `bus_out=zhi`, `bus_out_valid=1`.
  - On `bus_out_ready` → DONE.
- **DONE:** `done=1` for one cycle, → IDLE.
- **ERR:** `err=1` for one cycle, → IDLE; no register is modified except `alu_op`.
- **Stability:**
  - `alu_a`, `alu_b` and `alu_op` hold constant from capture until the return to IDLE.
  - `zhi`/`zlo` hold until the next Z latch.
- `start` outside IDLE is ignored.
- `bus_out` is 0 when `bus_out_valid=0`.

## Timing
- **Reset:** `clr=1` at any edge, including mid-operation, forces IDLE. All outputs read 0: `alu_a`, `alu_b`, `alu_op`, `zhi`, `zlo`, `bus_out`, `bus_out_valid`, `bus_in_ready`, `busy`, `done`, `err`. The counter is cleared. `clr` has priority over all other inputs.
- **Start:** `start` sampled high in cycle T gives `busy=1` in T+1.
- **Latency, binary op with back-to-back valid operands:** operands accepted in T+1 and T+2; EXEC covers T+3 … T+2+W; first `bus_out_valid` in T+3+W.
- **Latency, unary op:** one cycle shorter than the binary case.
- **Back-pressure:** a handshake completes only in a cycle where valid and ready are both high. `bus_out` must stay unchanged while `bus_out_ready=0`.
- **Completion:** `done` is asserted in the cycle after the final output handshake; `busy=0` in the cycle after `done`.
- **Illegal opcode:** `err` is high in T+1; `busy=1` in T+1, 0 in T+2.
- **Combinational paths:** none from any input to any output. All outputs are registered or decoded from state/registers.

## Test plan
- **Add:** add, bus_in 5 then 7, ready held high → single word `bus_out=0x0000000C` at T+4 (W=1); `done` at T+5; `zhi=0`.
- **Mul:** mul, operands 0x00010000 and 0x00010000 → OUT_LO word 0x00000000, then OUT_HI word 0x00000001; EXEC lasts exactly 4 cycles.
- **Neg:** neg, single operand 0x00000005 → `alu_a=0`, `bus_out=0xFFFFFFFB`, exactly one `bus_in_ready` handshake.
- **Back-pressure:** hold `bus_out_ready=0` for 3 cycles in OUT_LO of a sub 9−4 → `bus_out=0x00000005` stable for 4 cycles; `done` one cycle after ready rises.
- **Illegal opcode and ignored start:** `start` with opcode 01100 → `err` pulse at T+1, IDLE at T+2, all registers unchanged. `start` asserted mid-EXEC is ignored.
- **Reset mid-operation:** assert `clr` during the second EXEC cycle of a div → every output 0 next cycle. A subsequent add 1+1 then yields 0x00000002.
